// File: rtl/rc4_pkg.sv
// -----------------------------------------------------------------------------
// rc4_pkg
// Shared types and constants for the RC4 pipeline sequencer.
//   seq_state_t : sequencer FSM states
//   owner_t     : which requester currently drives the S-memory port
//   S_ADDR_W / S_DATA_W / S_DEPTH : S-memory geometry (256 x 8)
// -----------------------------------------------------------------------------
package rc4_pkg;

   localparam int S_ADDR_W = 8;
   localparam int S_DATA_W = 8;
   localparam int S_DEPTH  = 256;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      INIT_GO   = 3'd1,
      INIT_WAIT = 3'd2,
      SHUF_GO   = 3'd3,
      SHUF_WAIT = 3'd4,
      DEC_GO    = 3'd5,
      DEC_WAIT  = 3'd6,
      DONE      = 3'd7
   } seq_state_t;

   typedef enum logic [2:0] {
      OWN_NONE = 3'd0,
      OWN_INIT = 3'd1,
      OWN_SHUF = 3'd2,
      OWN_DEC  = 3'd3,
      OWN_DBG  = 3'd4
   } owner_t;

   // IDLE and DONE are the two resting states: not busy, debug may be granted.
   function automatic logic is_resting(input seq_state_t s);
      return (s == IDLE) || (s == DONE);
   endfunction

endpackage

// File: rtl/rc4_mem_mux.sv
// -----------------------------------------------------------------------------
// rc4_mem_mux
// Combinational 4-way selector of the S-memory request. The current owner's
// address/data/write-enable are passed through; every other requester is
// ignored. With no owner the port is driven to all zeros. The debug reader
// only ever reads, so its data and write enable are forced to zero.
// Ports:
//   i_owner                         current memory owner
//   i_init_* / i_shuf_* / i_dec_*   stage memory requests (addr, data, wren)
//   i_dbg_addr                      debug read address
//   o_mem_addr/o_mem_data/o_mem_wren  request presented to the S-memory
// -----------------------------------------------------------------------------
module rc4_mem_mux
   import rc4_pkg::*;
#(
   parameter int ADDR_W = S_ADDR_W,
   parameter int DATA_W = S_DATA_W
) (
   input  owner_t            i_owner,
   input  logic [ADDR_W-1:0] i_init_addr,
   input  logic [DATA_W-1:0] i_init_data,
   input  logic              i_init_wren,
   input  logic [ADDR_W-1:0] i_shuf_addr,
   input  logic [DATA_W-1:0] i_shuf_data,
   input  logic              i_shuf_wren,
   input  logic [ADDR_W-1:0] i_dec_addr,
   input  logic [DATA_W-1:0] i_dec_data,
   input  logic              i_dec_wren,
   input  logic [ADDR_W-1:0] i_dbg_addr,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_data,
   output logic              o_mem_wren
);

   always_comb begin
      o_mem_addr = '0;
      o_mem_data = '0;
      o_mem_wren = 1'b0;
      case (i_owner)
         OWN_INIT: begin
            o_mem_addr = i_init_addr;
            o_mem_data = i_init_data;
            o_mem_wren = i_init_wren;
         end
         OWN_SHUF: begin
            o_mem_addr = i_shuf_addr;
            o_mem_data = i_shuf_data;
            o_mem_wren = i_shuf_wren;
         end
         OWN_DEC: begin
            o_mem_addr = i_dec_addr;
            o_mem_data = i_dec_data;
            o_mem_wren = i_dec_wren;
         end
         OWN_DBG: begin
            o_mem_addr = i_dbg_addr;
         end
         default: begin
            o_mem_addr = '0;
         end
      endcase
   end

endmodule

// File: rtl/rc4_mem_sequencer.sv
// -----------------------------------------------------------------------------
// rc4_mem_sequencer
// Runs the RC4 init -> shuffle -> decrypt stages one after another and owns
// the single-port S-memory, handing it to whichever stage is active. While
// the pipeline rests (IDLE/DONE) a debug reader may be granted read access.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   start, abort                    run request pulse / return-to-idle level
//   busy, done                      run status
//   init/shuf/dec_start             one-cycle stage start pulses
//   init/shuf/dec_complete          one-cycle stage completion pulses
//   init/shuf/dec_addr/data/wren    stage memory requests
//   mem_addr, mem_data, mem_wren    S-memory request
//   mem_q                           S-memory read data (1-cycle latency)
//   dbg_req, dbg_addr               debug read request
//   dbg_gnt, dbg_rvalid, dbg_rdata  debug grant and returned read data
// -----------------------------------------------------------------------------
module rc4_mem_sequencer
   import rc4_pkg::*;
#(
   parameter int ADDR_W = S_ADDR_W,
   parameter int DATA_W = S_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic              init_start,
   output logic              shuf_start,
   output logic              dec_start,
   input  logic              init_complete,
   input  logic              shuf_complete,
   input  logic              dec_complete,
   input  logic [ADDR_W-1:0] init_addr,
   input  logic [DATA_W-1:0] init_data,
   input  logic              init_wren,
   input  logic [ADDR_W-1:0] shuf_addr,
   input  logic [DATA_W-1:0] shuf_data,
   input  logic              shuf_wren,
   input  logic [ADDR_W-1:0] dec_addr,
   input  logic [DATA_W-1:0] dec_data,
   input  logic              dec_wren,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_data,
   output logic              mem_wren,
   input  logic              dbg_req,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic              dbg_gnt,
   output logic              dbg_rvalid,
   output logic [DATA_W-1:0] dbg_rdata,
   input  logic [DATA_W-1:0] mem_q
);

   seq_state_t r_state;
   seq_state_t w_next_state;
   owner_t     r_owner;
   owner_t     w_owner_next;
   logic       r_dbg_gnt;
   logic       r_dbg_rvalid;
   logic       w_gnt_next;

   // A grant is only issued from a resting state, and a start in the same
   // cycle wins so the memory is never shared with the init stage.
   assign w_gnt_next = dbg_req && is_resting(r_state) && !start;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_owner      <= OWN_NONE;
         r_dbg_gnt    <= 1'b0;
         r_dbg_rvalid <= 1'b0;
      end else begin
         r_state      <= w_next_state;
         r_owner      <= w_owner_next;
         r_dbg_gnt    <= w_gnt_next;
         r_dbg_rvalid <= r_dbg_gnt;
      end
   end

   // Next state and state-decoded outputs. Abort overrides everything,
   // including start and any completion pulse arriving in the same cycle.
   always_comb begin
      w_next_state = r_state;
      busy         = !is_resting(r_state);
      done         = (r_state == DONE);
      init_start   = (r_state == INIT_GO);
      shuf_start   = (r_state == SHUF_GO);
      dec_start    = (r_state == DEC_GO);
      if (abort) begin
         w_next_state = IDLE;
      end else begin
         case (r_state)
            IDLE, DONE: if (start)         w_next_state = INIT_GO;
            INIT_GO:                       w_next_state = INIT_WAIT;
            INIT_WAIT:  if (init_complete) w_next_state = SHUF_GO;
            SHUF_GO:                       w_next_state = SHUF_WAIT;
            SHUF_WAIT:  if (shuf_complete) w_next_state = DEC_GO;
            DEC_GO:                        w_next_state = DEC_WAIT;
            DEC_WAIT:   if (dec_complete)  w_next_state = DONE;
            default:                       w_next_state = IDLE;
         endcase
      end
   end

   // Owner is registered from the next state so the new owner's requests
   // reach the memory in the same cycle its start pulse is issued.
   always_comb begin
      w_owner_next = OWN_NONE;
      case (w_next_state)
         INIT_GO, INIT_WAIT: w_owner_next = OWN_INIT;
         SHUF_GO, SHUF_WAIT: w_owner_next = OWN_SHUF;
         DEC_GO, DEC_WAIT:   w_owner_next = OWN_DEC;
         default:            w_owner_next = w_gnt_next ? OWN_DBG : OWN_NONE;
      endcase
   end

   rc4_mem_mux #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_mem_mux (
      .i_owner     (r_owner),
      .i_init_addr (init_addr),
      .i_init_data (init_data),
      .i_init_wren (init_wren),
      .i_shuf_addr (shuf_addr),
      .i_shuf_data (shuf_data),
      .i_shuf_wren (shuf_wren),
      .i_dec_addr  (dec_addr),
      .i_dec_data  (dec_data),
      .i_dec_wren  (dec_wren),
      .i_dbg_addr  (dbg_addr),
      .o_mem_addr  (mem_addr),
      .o_mem_data  (mem_data),
      .o_mem_wren  (mem_wren)
   );

   assign dbg_gnt    = r_dbg_gnt;
   assign dbg_rvalid = r_dbg_rvalid;
   // Memory read data lands one cycle after the granted address cycle.
   assign dbg_rdata  = r_dbg_rvalid ? mem_q : '0;

endmodule

// File: tb/tb_rc4_mem_sequencer.sv
module tb_rc4_mem_sequencer;
   import rc4_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       start = 1'b0, abort = 1'b0;
   logic       init_complete = 1'b0, shuf_complete = 1'b0, dec_complete = 1'b0;
   logic [7:0] init_addr = '0, init_data = '0, shuf_addr = '0, shuf_data = '0;
   logic [7:0] dec_addr = '0, dec_data = '0;
   logic       init_wren = 1'b0, shuf_wren = 1'b0, dec_wren = 1'b0;
   logic       dbg_req = 1'b0;
   logic [7:0] dbg_addr = '0;
   logic [7:0] mem_q = '0;
   logic       busy, done, init_start, shuf_start, dec_start;
   logic [7:0] mem_addr, mem_data;
   logic       mem_wren, dbg_gnt, dbg_rvalid;
   logic [7:0] dbg_rdata;

   rc4_mem_sequencer #(.ADDR_W(8), .DATA_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .busy(busy), .done(done),
      .init_start(init_start), .shuf_start(shuf_start), .dec_start(dec_start),
      .init_complete(init_complete), .shuf_complete(shuf_complete), .dec_complete(dec_complete),
      .init_addr(init_addr), .init_data(init_data), .init_wren(init_wren),
      .shuf_addr(shuf_addr), .shuf_data(shuf_data), .shuf_wren(shuf_wren),
      .dec_addr(dec_addr), .dec_data(dec_data), .dec_wren(dec_wren),
      .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren),
      .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_gnt(dbg_gnt),
      .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata), .mem_q(mem_q)
   );

   always #5 clk = ~clk;

   // S-memory: 1-cycle read latency, read-before-write
   logic [7:0] mem [0:S_DEPTH-1];
   logic       preload_en = 1'b0;
   logic [7:0] preload_addr = '0, preload_val = '0;
   always @(posedge clk) begin
      mem_q <= mem[mem_addr];
      if (preload_en)    mem[preload_addr] <= preload_val;
      else if (mem_wren) mem[mem_addr] <= mem_data;
   end

   int n_checks = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: which stage is running (0 = resting, 1..3), whether it
   // is in its first (start) cycle, and whether the last run completed.
   int         m_stage = 0;
   bit         m_go = 0, m_done = 0, m_gnt = 0, m_rvalid = 0;
   logic [7:0] m_rdata = '0;

   function automatic void model_reset();
      m_stage = 0; m_go = 0; m_done = 0; m_gnt = 0; m_rvalid = 0; m_rdata = '0;
   endfunction

   // Advance the model across one rising edge using the inputs held before it.
   function automatic void model_update();
      int       os = m_stage;
      bit       og = m_gnt;
      bit [3:1] cmp;
      cmp = {dec_complete, shuf_complete, init_complete};
      if (!rst_n) begin
         model_reset();
         return;
      end
      m_rvalid = og;
      if (og) m_rdata = mem[dbg_addr];
      m_gnt = dbg_req && (os == 0) && !start;
      if (abort) begin
         m_stage = 0; m_go = 0; m_done = 0;
      end else if (os == 0) begin
         if (start) begin m_stage = 1; m_go = 1; m_done = 0; end
      end else if (m_go) begin
         m_go = 0;
      end else if (cmp[os]) begin
         if (os == 3) begin m_stage = 0; m_done = 1; end
         else begin m_stage = os + 1; m_go = 1; end
      end
   endfunction

   // Environment: stage models answer start with complete after lat cycles.
   logic [3:1] se = '0;
   int         n_start [1:3] = '{0, 0, 0};
   int         cnt [1:3] = '{0, 0, 0};
   int         lat = 257;
   bit         k_start = 0, k_abort = 0, k_dbg_req = 0, k_iso = 0, k_stray = 0;
   logic [7:0] k_dbg_addr = '0;

   // Single compare process: every cycle, on the falling edge.
   initial forever begin
      logic [7:0] ea, ed;
      logic       ew;
      @(negedge clk);
      ea = '0; ed = '0; ew = 1'b0;
      case (m_stage)
         1: begin ea = init_addr; ed = init_data; ew = init_wren; end
         2: begin ea = shuf_addr; ed = shuf_data; ew = shuf_wren; end
         3: begin ea = dec_addr;  ed = dec_data;  ew = dec_wren;  end
         default: if (m_gnt) ea = dbg_addr;
      endcase
      chk("busy", busy, m_stage != 0);
      chk("done", done, (m_stage == 0) && m_done);
      chk("init_start", init_start, m_go && m_stage == 1);
      chk("shuf_start", shuf_start, m_go && m_stage == 2);
      chk("dec_start", dec_start, m_go && m_stage == 3);
      chk("mem_addr", mem_addr, ea);
      chk("mem_data", mem_data, ed);
      chk("mem_wren", mem_wren, ew);
      chk("dbg_gnt", dbg_gnt, m_gnt);
      chk("dbg_rvalid", dbg_rvalid, m_rvalid);
      chk("dbg_rdata", dbg_rdata, m_rvalid ? m_rdata : 8'h00);
      se = {dec_start, shuf_start, init_start};
      for (int k = 1; k <= 3; k++) if (se[k]) n_start[k]++;
   end

   // One clock cycle: update model at the edge, then drive the next inputs.
   task automatic cycle();
      logic [3:1] c;
      @(posedge clk);
      model_update();
      for (int k = 1; k <= 3; k++) begin
         if (!rst_n || k_abort) cnt[k] = 0;
         else if (se[k]) cnt[k] = lat;
         else if (cnt[k] > 0) cnt[k]--;
      end
      #1;
      for (int k = 1; k <= 3; k++) c[k] = (cnt[k] == 1) || (k_stray && $urandom_range(0, 3) == 0);
      init_complete = c[1]; shuf_complete = c[2]; dec_complete = c[3];
      start = k_start; k_start = 0;
      abort = k_abort; k_abort = 0;
      init_addr = 8'($urandom); init_data = 8'($urandom); init_wren = 1'($urandom);
      shuf_addr = 8'($urandom); shuf_data = 8'($urandom); shuf_wren = 1'($urandom);
      dec_addr  = 8'($urandom); dec_data  = 8'($urandom); dec_wren  = 1'($urandom);
      if (k_iso) begin shuf_wren = 1'b1; shuf_addr = 8'h55; end
      dbg_req = k_dbg_req; dbg_addr = k_dbg_addr;
   endtask

   task automatic clear_counts();
      for (int k = 1; k <= 3; k++) n_start[k] = 0;
   endtask

   initial begin
      logic [3:1] pc;
      // ---- reset state ----
      #2 rst_n = 1'b0;
      #1;
      chk("rst_busy", busy, 0);       chk("rst_done", done, 0);
      chk("rst_init_start", init_start, 0);
      chk("rst_mem_addr", mem_addr, 0); chk("rst_mem_wren", mem_wren, 0);
      chk("rst_dbg_gnt", dbg_gnt, 0); chk("rst_dbg_rdata", dbg_rdata, 0);
      repeat (3) cycle();
      rst_n = 1'b1;
      repeat (2) cycle();

      // ---- full run, 257-cycle stage latency, ownership isolation ----
      clear_counts();
      lat = 257; k_start = 1;
      cycle();
      cycle();
      #2 chk("run_init_start", init_start, 1);
      chk("run_busy", busy, 1);
      repeat (3) cycle();
      k_iso = 1;
      repeat (4) begin
         cycle();
         #2 chk("iso_addr", mem_addr, init_addr);
         chk("iso_wren", mem_wren, init_wren);
      end
      k_iso = 0;
      for (int i = 0; i < 1200 && !done; i++) begin
         pc = {dec_complete, shuf_complete, init_complete};
         cycle();
         #2;
         if (pc[1]) chk("handoff_shuf", shuf_start, 1);
         if (pc[2]) chk("handoff_dec", dec_start, 1);
      end
      chk("run_done", done, 1);
      chk("run_idle", busy, 0);
      chk("run_n_init", n_start[1], 1);
      chk("run_n_shuf", n_start[2], 1);
      chk("run_n_dec", n_start[3], 1);

      // ---- debug read in DONE ----
      preload_addr = 8'h10; preload_val = 8'hA7; preload_en = 1'b1;
      cycle();
      preload_en = 1'b0;
      k_dbg_req = 1; k_dbg_addr = 8'h10;
      cycle();
      #2 chk("dbg_gnt_wait", dbg_gnt, 0);
      k_dbg_req = 0;
      cycle();
      #2 chk("dbg_gnt_up", dbg_gnt, 1);
      chk("dbg_addr_out", mem_addr, 8'h10);
      chk("dbg_no_wr", mem_wren, 0);
      cycle();
      #2 chk("dbg_rvalid", dbg_rvalid, 1);
      chk("dbg_rdata_a7", dbg_rdata, 8'hA7);
      chk("dbg_no_wr2", mem_wren, 0);

      // ---- abort mid-shuffle ----
      lat = 10; k_start = 1;
      for (int i = 0; i < 200 && !shuf_start; i++) cycle();
      repeat (3) cycle();
      clear_counts();
      k_abort = 1;
      cycle();
      cycle();
      #2 chk("abort_busy", busy, 0);
      chk("abort_wren", mem_wren, 0);
      repeat (40) cycle();
      chk("abort_no_dec", n_start[3], 0);

      // ---- abort together with start ----
      k_start = 1; k_abort = 1;
      cycle();
      cycle();
      #2 chk("abort_start_busy", busy, 0);
      chk("abort_start_init", init_start, 0);

      // ---- debug blocked while busy ----
      lat = 15; k_start = 1;
      for (int i = 0; i < 300 && !dec_start; i++) cycle();
      k_dbg_req = 1; k_dbg_addr = 8'h33;
      for (int i = 0; i < 100 && !done; i++) begin
         cycle();
         #2 chk("dbg_blocked", dbg_gnt, 0);
      end
      cycle();
      #2 chk("dbg_after_done", dbg_gnt, 1);
      k_dbg_req = 0;
      repeat (3) cycle();

      // ---- async reset mid INIT_WAIT, then stray completes ----
      lat = 30; k_start = 1;
      repeat (8) cycle();
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      chk("arst_busy", busy, 0);     chk("arst_mem_addr", mem_addr, 0);
      chk("arst_mem_data", mem_data, 0); chk("arst_mem_wren", mem_wren, 0);
      chk("arst_dbg_rvalid", dbg_rvalid, 0);
      k_stray = 1;
      repeat (3) cycle();
      rst_n = 1'b1;
      repeat (10) begin
         cycle();
         #2 chk("stray_idle", busy, 0);
      end
      k_stray = 0;
      repeat (3) cycle();

      // ---- randomized operation ----
      for (int i = 0; i < 3000; i++) begin
         k_start    = ($urandom_range(0, 39) == 0);
         k_abort    = ($urandom_range(0, 149) == 0);
         k_dbg_req  = ($urandom_range(0, 2) == 0);
         k_dbg_addr = 8'($urandom);
         k_stray    = ($urandom_range(0, 29) == 0);
         lat        = $urandom_range(2, 12);
         cycle();
      end
      k_dbg_req = 0; k_stray = 0;
      repeat (2) cycle();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
